// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the fetch PC, fills the IF/ID register,
// and handles stall, redirect/flush and halt/resume.
module fetch_controller #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = 8'h00,
  parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    pc_out,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  input  logic                   resume,
  output logic                   ifid_valid,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc,
  output logic                   halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_next;

  // Sequential fetch address, wrapping modulo 2^PC_WIDTH.
  assign pc_next = pc_out + PC_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      pc_out     <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      halted     <= 1'b0;
    end else begin
      case (state)
        // Post-reset cycle for instruction memory; nothing is captured.
        BOOT: state <= RUN;

        RUN: begin
          if (redirect_valid) begin
            // Redirect beats both stall and a freshly fetched halt opcode.
            pc_out     <= redirect_target;
            ifid_valid <= 1'b0;
          end else if (!stall) begin
            ifid_instr <= instr_in;
            ifid_pc    <= pc_out;
            ifid_valid <= 1'b1;
            if (instr_in == HALT_OPCODE) state <= HALT;
            else                         pc_out <= pc_next;
          end
        end

        HALT: begin
          // The halt instruction was delivered once; keep IF/ID empty.
          ifid_valid <= 1'b0;
          if (redirect_valid) begin
            pc_out <= redirect_target;
            state  <= RUN;
            halted <= 1'b0;
          end else if (resume) begin
            pc_out <= pc_next;
            state  <= RUN;
            halted <= 1'b0;
          end else begin
            halted <= 1'b1;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller against a combinational memory with
// mem[i] = i + 8'h10 (patched per scenario).
module tb_fetch_controller;

  logic       clk;
  logic       reset;
  logic [7:0] pc_out;
  logic [7:0] instr_in;
  logic       stall;
  logic       redirect_valid;
  logic [7:0] redirect_target;
  logic       resume;
  logic       ifid_valid;
  logic [7:0] ifid_instr;
  logic [7:0] ifid_pc;
  logic       halted;

  logic [7:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;

  fetch_controller dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .instr_in(instr_in),
    .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .resume(resume),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .halted(halted)
  );

  assign instr_in = mem[pc_out];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00; resume = 1'b0;
    step(); step();
    n_cmp++; if (pc_out !== 8'h00) begin n_err++; $display("FAIL reset.pc_out got %h want 00", pc_out); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL reset.ifid_valid got %b want 0", ifid_valid); end
    n_cmp++; if (ifid_instr !== 8'h00) begin n_err++; $display("FAIL reset.ifid_instr got %h want 00", ifid_instr); end
    n_cmp++; if (ifid_pc !== 8'h00) begin n_err++; $display("FAIL reset.ifid_pc got %h want 00", ifid_pc); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset.halted got %b want 0", halted); end
  endtask

  // Cycle 0 is BOOT, cycle 1 captures, valid from cycle 2; runs until ifid_pc=5.
  task automatic test_free_run();
    reset = 1'b0;
    step();
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL boot.ifid_valid got %b want 0", ifid_valid); end
    n_cmp++; if (pc_out !== 8'h00) begin n_err++; $display("FAIL boot.pc_out got %h want 00", pc_out); end
    for (int k = 0; k <= 5; k++) begin
      step();
      n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL run.ifid_valid k=%0d got %b want 1", k, ifid_valid); end
      n_cmp++; if (ifid_pc !== 8'(k)) begin n_err++; $display("FAIL run.ifid_pc got %h want %h", ifid_pc, 8'(k)); end
      n_cmp++; if (ifid_instr !== 8'(k + 16)) begin n_err++; $display("FAIL run.ifid_instr got %h want %h", ifid_instr, 8'(k + 16)); end
      n_cmp++; if (pc_out !== 8'(k + 1)) begin n_err++; $display("FAIL run.pc_out got %h want %h", pc_out, 8'(k + 1)); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (pc_out !== 8'h06) begin n_err++; $display("FAIL stall.pc_out got %h want 06", pc_out); end
      n_cmp++; if (ifid_pc !== 8'h05) begin n_err++; $display("FAIL stall.ifid_pc got %h want 05", ifid_pc); end
      n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL stall.ifid_valid got %b want 1", ifid_valid); end
    end
    stall = 1'b0;
    step();
    n_cmp++; if (ifid_pc !== 8'h06) begin n_err++; $display("FAIL unstall.ifid_pc got %h want 06", ifid_pc); end
    step();
    n_cmp++; if (ifid_pc !== 8'h07) begin n_err++; $display("FAIL unstall2.ifid_pc got %h want 07", ifid_pc); end
    n_cmp++; if (pc_out !== 8'h08) begin n_err++; $display("FAIL unstall2.pc_out got %h want 08", pc_out); end
  endtask

  task automatic test_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h40;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    n_cmp++; if (pc_out !== 8'h40) begin n_err++; $display("FAIL redir.pc_out got %h want 40", pc_out); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL redir.bubble got %b want 0", ifid_valid); end
    step();
    n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL redir.ifid_valid got %b want 1", ifid_valid); end
    n_cmp++; if (ifid_pc !== 8'h40) begin n_err++; $display("FAIL redir.ifid_pc got %h want 40", ifid_pc); end
    n_cmp++; if (ifid_instr !== 8'h50) begin n_err++; $display("FAIL redir.ifid_instr got %h want 50", ifid_instr); end
    n_cmp++; if (pc_out !== 8'h41) begin n_err++; $display("FAIL redir.pc_out2 got %h want 41", pc_out); end
  endtask

  task automatic test_halt();
    mem[7] = 8'hFF;
    redirect_valid = 1'b1; redirect_target = 8'h06;
    step();
    redirect_valid = 1'b0;
    step();  // captures 6, pc_out=7 presents halt opcode
    step();  // captures halt
    n_cmp++; if (ifid_instr !== 8'hFF) begin n_err++; $display("FAIL halt.ifid_instr got %h want ff", ifid_instr); end
    n_cmp++; if (ifid_pc !== 8'h07) begin n_err++; $display("FAIL halt.ifid_pc got %h want 07", ifid_pc); end
    n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL halt.ifid_valid got %b want 1", ifid_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt.early_halted got %b want 0", halted); end
    stall = 1'b1;  // ignored in HALT
    step();
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt.halted got %b want 1", halted); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL halt.once got %b want 0", ifid_valid); end
    n_cmp++; if (pc_out !== 8'h07) begin n_err++; $display("FAIL halt.pc_out got %h want 07", pc_out); end
    step();
    n_cmp++; if (halted !== 1'b1 || pc_out !== 8'h07 || ifid_instr !== 8'hFF) begin n_err++; $display("FAIL halt.hold halted=%b pc=%h instr=%h want 1/07/ff", halted, pc_out, ifid_instr); end
    stall = 1'b0; resume = 1'b1;
    step();
    resume = 1'b0;
    n_cmp++; if (pc_out !== 8'h08) begin n_err++; $display("FAIL resume.pc_out got %h want 08", pc_out); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL resume.halted got %b want 0", halted); end
    step();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 8'h08 || ifid_instr !== 8'h18) begin n_err++; $display("FAIL resume.capture v=%b pc=%h instr=%h want 1/08/18", ifid_valid, ifid_pc, ifid_instr); end
    // Redirect arriving while halt opcode is on instr_in wins.
    redirect_valid = 1'b1; redirect_target = 8'h07;
    step();
    redirect_target = 8'h30;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (pc_out !== 8'h30 || ifid_valid !== 1'b0) begin n_err++; $display("FAIL redir_vs_halt.pc=%h v=%b want 30/0", pc_out, ifid_valid); end
    step();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 8'h30 || halted !== 1'b0) begin n_err++; $display("FAIL redir_vs_halt.run v=%b pc=%h h=%b want 1/30/0", ifid_valid, ifid_pc, halted); end
    mem[7] = 8'h17;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 8'hFE;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 8'(254 + k)) begin n_err++; $display("FAIL wrap.ifid_pc got %h v=%b want %h v=1", ifid_pc, ifid_valid, 8'(254 + k)); end
      n_cmp++; if (ifid_instr !== 8'(254 + k + 16)) begin n_err++; $display("FAIL wrap.ifid_instr got %h want %h", ifid_instr, 8'(254 + k + 16)); end
    end
  endtask

  task automatic test_reset_mid();
    redirect_valid = 1'b1; redirect_target = 8'h20;
    step();
    redirect_valid = 1'b0;
    step(); step();
    n_cmp++; if (pc_out !== 8'h22) begin n_err++; $display("FAIL rmid.pre_pc got %h want 22", pc_out); end
    stall = 1'b1; reset = 1'b1;
    step();
    n_cmp++; if (pc_out !== 8'h00 || ifid_valid !== 1'b0 || ifid_instr !== 8'h00 || ifid_pc !== 8'h00 || halted !== 1'b0)
      begin n_err++; $display("FAIL rmid.reset pc=%h v=%b instr=%h ipc=%h h=%b want 00/0/00/00/0", pc_out, ifid_valid, ifid_instr, ifid_pc, halted); end
    stall = 1'b0; reset = 1'b0;
    step();
    n_cmp++; if (ifid_valid !== 1'b0 || pc_out !== 8'h00) begin n_err++; $display("FAIL rmid.boot v=%b pc=%h want 0/00", ifid_valid, pc_out); end
    step();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 8'h00 || ifid_instr !== 8'h10 || pc_out !== 8'h01)
      begin n_err++; $display("FAIL rmid.first v=%b ipc=%h instr=%h pc=%h want 1/00/10/01", ifid_valid, ifid_pc, ifid_instr, pc_out); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
